// File: rtl/r22sdf_pkg.sv
// Shared types and helpers for the R2^2 SDF FFT pipeline.
// Holds the stream-controller state set and pipeline latency math.
package r22sdf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } r22sdf_state_e;

  // Delay lines sum to N-1; each radix-2^2 stage adds its DSP registers.
  function automatic int r22sdf_latency(
    input int fft_length,
    input int ff_in,
    input int ff_out,
    input int dsp_ff_num
  );
    int stages;
    stages = $clog2(fft_length) / 2;
    return (fft_length - 1) + ff_in + ff_out
      + stages * dsp_ff_num;
  endfunction

  function automatic int r22sdf_cnt_w(input int pipe_latency);
    return $clog2(pipe_latency + 1);
  endfunction

endpackage

// File: rtl/r22sdf_stream_ctrl.sv
// Stream flow controller for the R2^2 SDF FFT pipeline.
// Tracks real vs fill slots, flushes the last frame, flags frames.
module r22sdf_stream_ctrl
  import r22sdf_pkg::*;
#(
  parameter int unsigned fft_length   = 256,
  parameter int unsigned pipe_latency = 268
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cordic_rdy,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        flush_req,
  output logic        fft_en,
  output logic        din_zero,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sop,
  output logic        m_eop,
  output logic        busy,
  output logic [15:0] frames_out
);

  localparam int CW = r22sdf_cnt_w(int'(pipe_latency));
  localparam int IW = $clog2(fft_length);
  localparam logic [IW-1:0] LAST = IW'(fft_length - 1);
  localparam logic [CW-1:0] LAT  = CW'(pipe_latency);

  r22sdf_state_e state;

  logic [CW-1:0] gap;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_next;
  logic [IW-1:0] in_cnt;
  logic [IW-1:0] out_cnt;
  logic          flush_pend;
  logic          can_adv;
  logic          in_v;
  logic          in_xfer;
  logic          frame_hold;

  assign m_valid    = (gap == '0) && (occ != '0);
  assign can_adv    = cordic_rdy && (!m_valid || m_ready);
  assign frame_hold = flush_pend && (in_cnt == '0)
                      && (state == ST_RUN);
  assign in_v       = (state != ST_FLUSH);
  assign s_ready    = can_adv && in_v && !frame_hold;
  assign fft_en     = in_v ? (s_valid && s_ready) : can_adv;
  assign in_xfer    = in_v && fft_en;
  assign m_sop      = m_valid && (out_cnt == '0);
  assign m_eop      = m_valid && (out_cnt == LAST);
  assign din_zero   = (state == ST_FLUSH);
  assign busy       = (state != ST_IDLE);

  // Occupancy after this cycle: real samples enter, the head leaves.
  always_comb begin
    occ_next = occ;
    if (fft_en)
      occ_next = occ + CW'(in_v) - CW'(m_valid);
  end

  // Slot bookkeeping, frame counters and IDLE/RUN/FLUSH sequencing.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      gap        <= LAT;
      occ        <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      flush_pend <= 1'b0;
      frames_out <= '0;
    end else begin
      occ <= occ_next;
      if (fft_en && gap != '0)
        gap <= gap - CW'(1);
      if (in_xfer)
        in_cnt <= in_cnt + IW'(1);
      if (m_valid && fft_en)
        out_cnt <= out_cnt + IW'(1);
      if (m_eop && fft_en)
        frames_out <= frames_out + 16'd1;
      if (flush_req && state == ST_RUN)
        flush_pend <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (in_xfer)
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (flush_pend && in_cnt == '0) begin
            state      <= ST_FLUSH;
            flush_pend <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (occ_next == '0) begin
            state <= ST_IDLE;
            gap   <= LAT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r22sdf_stream_ctrl.sv
// Bench for r22sdf_stream_ctrl: slot-queue reference model,
// output scoreboard, directed scenarios and random traffic.
module tb_r22sdf_stream_ctrl;

  localparam int FL  = 16;
  localparam int LAT = 20;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cr = 1'b0;
  logic sv = 1'b1;
  logic mr = 1'b1;
  logic fr = 1'b0;
  logic s_ready, fft_en, din_zero, m_valid;
  logic m_sop, m_eop, busy;
  logic [15:0] frames_out;

  int n_cmp = 0;
  int n_err = 0;

  bit g_acc, g_dz, g_busy, g_mv;

  bit pq[$];
  int mst, in_mod, out_mod, frames, seq;
  bit fpend;
  int exp_q[$];

  r22sdf_stream_ctrl #(
    .fft_length(FL),
    .pipe_latency(LAT)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .cordic_rdy(cr),
    .s_valid(sv),
    .s_ready(s_ready),
    .flush_req(fr),
    .fft_en(fft_en),
    .din_zero(din_zero),
    .m_valid(m_valid),
    .m_ready(mr),
    .m_sop(m_sop),
    .m_eop(m_eop),
    .busy(busy),
    .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    pq.delete();
    for (int i = 0; i < LAT; i++) pq.push_back(1'b0);
    mst = M_IDLE; fpend = 1'b0;
    in_mod = 0; out_mod = 0; frames = 0; seq = 0;
    exp_q.delete();
  endfunction

  initial model_reset();

  // Reference: the pipe is a queue of LAT slots, head = output.
  always @(negedge clk) begin : model
    bit mv, can, srdy, en, any, sop, eop;
    int nst;
    bit nfp;
    mv   = pq[0];
    can  = cr && (!mv || mr);
    srdy = can && (mst != M_FLUSH)
           && !(fpend && in_mod == 0 && mst == M_RUN);
    en   = (mst == M_FLUSH) ? can : (sv && srdy);
    sop  = mv && out_mod == 0;
    eop  = mv && out_mod == FL - 1;
    chk("s_ready", s_ready, srdy);
    chk("fft_en", fft_en, en);
    chk("m_valid", m_valid, mv);
    chk("m_sop", m_sop, sop);
    chk("m_eop", m_eop, eop);
    chk("din_zero", din_zero, mst == M_FLUSH);
    chk("busy", busy, mst != M_IDLE);
    chk("frames_out", frames_out, frames & 16'hffff);
    if (rst) begin
      model_reset();
    end else begin
      nst = mst; nfp = fpend;
      if (fr && mst == M_RUN) nfp = 1'b1;
      if (mst == M_RUN && fpend && in_mod == 0) begin
        nst = M_FLUSH; nfp = 1'b0;
      end
      if (en) begin
        if (mv) begin
          out_mod = (out_mod + 1) % FL;
          if (eop) frames++;
        end
        void'(pq.pop_front());
        pq.push_back(mst != M_FLUSH);
        if (mst != M_FLUSH) begin
          exp_q.push_back(seq);
          seq++;
          in_mod = (in_mod + 1) % FL;
          if (mst == M_IDLE) nst = M_RUN;
        end
      end
      if (mst == M_FLUSH) begin
        any = 1'b0;
        foreach (pq[i]) if (pq[i]) any = 1'b1;
        if (!any) nst = M_IDLE;
      end
      mst = nst; fpend = nfp;
    end
  end

  // Scoreboard monitor: each output transfer matches the next input.
  always @(negedge clk) begin : monitor
    int s;
    if (!rst && m_valid && mr && fft_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_empty: got output want none");
      end else begin
        s = exp_q.pop_front();
        chk("sb_sop", m_sop, (s % FL) == 0);
        chk("sb_eop", m_eop, (s % FL) == FL - 1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    g_acc  = sv && s_ready;
    g_dz   = din_zero;
    g_busy = busy;
    g_mv   = m_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input bit fl);
    int guard;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      sv = 1'b1;
      fr = fl && (k == n - 1);
      do begin
        step();
        fr = 1'b0;
        guard++;
      end while (!g_acc && guard < 200);
      if (!g_acc) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: got no accept want accept");
      end
    end
    sv = 1'b0;
  endtask

  task automatic wait_idle(output int zc);
    int g;
    g = 0; zc = 0; sv = 1'b0; fr = 1'b0;
    do begin
      step();
      if (g_dz) zc++;
      g++;
    end while (g_busy && g < 500);
    if (g_busy) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: got busy want idle");
    end
  endtask

  initial begin
    int zc, g;
    step(); step();
    rst = 1'b0;
    repeat (50) step();
    chk("stall_no_accept", g_acc, 0);
    cr = 1'b1; sv = 1'b0;
    step();

    send(16, 1'b1);
    wait_idle(zc);
    chk("lone_flush_len", zc, LAT);

    send(48, 1'b1);
    wait_idle(zc);
    chk("stream_flush_len", zc, LAT);

    send(25, 1'b0);
    mr = 1'b0; sv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("bp_stall", g_acc, 0);
    end
    mr = 1'b1;
    send(7, 1'b1);
    wait_idle(zc);
    chk("bp_flush_len", zc, LAT);

    send(5, 1'b0);
    fr = 1'b1;
    step();
    fr = 1'b0;
    send(11, 1'b0);
    wait_idle(zc);
    chk("mid_req_flush_len", zc, LAT);

    send(16, 1'b1);
    zc = 0; g = 0;
    while (zc < 11 && g < 200) begin
      step();
      if (g_dz) zc++;
      g++;
    end
    chk("pre_rst_flush_cnt", zc, 11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_busy", g_busy, 0);
    chk("rst_mvalid", g_mv, 0);
    send(16, 1'b1);
    wait_idle(zc);
    chk("post_rst_flush_len", zc, LAT);

    for (int i = 0; i < 600; i++) begin
      sv = ($urandom % 4) != 0;
      mr = ($urandom % 4) != 0;
      cr = ($urandom % 8) != 0;
      fr = ($urandom % 40) == 0;
      step();
    end

    cr = 1'b1; mr = 1'b1; sv = 1'b0; fr = 1'b0;
    step();
    g = 0;
    while (g_busy && g < 1000) begin
      sv = !g_dz;
      fr = 1'b1;
      step();
      g++;
    end
    sv = 1'b0; fr = 1'b0;
    step();
    chk("drain_idle", g_busy, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
